// File: rtl/carton_packer_ctrl_pkg.sv
// carton_packer_ctrl_pkg: state encoding and default timing constants for the carton packer.
package carton_packer_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_SEAL    = 2'd2,
    ST_ADVANCE = 2'd3
  } state_t;
  localparam int DEF_SEAL_CYCLES      = 4;
  localparam int DEF_ADV_CYCLES       = 3;
  localparam int DEF_BOXES_PER_PALLET = 10;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/edge_rise_det.sv
// edge_rise_det: rising-edge detector; history resets high so a level already high at reset is not an edge.
module edge_rise_det (
  input  logic Ck,
  input  logic clear,
  input  logic d,
  output logic rise
);
  logic r_prev;
  always_ff @(posedge Ck) r_prev <= clear ? 1'b1 : d;
  assign rise = d & ~r_prev;
endmodule

// File: rtl/carton_packer_ctrl.sv
// carton_packer_ctrl: sequences egg feed, box seal and conveyor advance, and counts boxes per pallet.
module carton_packer_ctrl
  import carton_packer_ctrl_pkg::*;
#(
  parameter int SEAL_CYCLES      = DEF_SEAL_CYCLES,
  parameter int ADV_CYCLES       = DEF_ADV_CYCLES,
  parameter int BOXES_PER_PALLET = DEF_BOXES_PER_PALLET
) (
  input  logic       Ck,
  input  logic       clear,
  input  logic       run,
  input  logic       dozen_done,
  output logic       feed_en,
  output logic       count_clear,
  output logic       seal,
  output logic       advance,
  output logic [3:0] box_count,
  output logic       pallet_full
);
  localparam int TW = $clog2(max_int(SEAL_CYCLES, ADV_CYCLES) + 1);
  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [3:0]      r_box_count;
  logic            w_rise;
  logic            w_timer_done;
  logic            w_last_box;
  edge_rise_det u_rise (
    .Ck   (Ck),
    .clear(clear),
    .d    (dozen_done),
    .rise (w_rise)
  );
  assign w_timer_done = r_timer == '0;
  assign w_last_box   = r_box_count == 4'(BOXES_PER_PALLET - 1);
  // One down-counter serves both SEAL and ADVANCE; each reloads it on entry.
  always_ff @(posedge Ck) begin
    if (clear) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_box_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= run ? ST_FILL : ST_IDLE;
        ST_FILL: begin
          if (w_rise) begin
            r_state <= ST_SEAL;
            r_timer <= TW'(SEAL_CYCLES - 1);
          end else if (!run) begin
            r_state <= ST_IDLE;
          end
        end
        ST_SEAL: begin
          if (w_timer_done) begin
            r_state <= ST_ADVANCE;
            r_timer <= TW'(ADV_CYCLES - 1);
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_ADVANCE: begin
          if (w_timer_done) begin
            r_box_count <= w_last_box ? '0 : r_box_count + 1'b1;
            r_state     <= (run && !w_last_box) ? ST_FILL : ST_IDLE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign feed_en     = r_state == ST_FILL;
  assign seal        = r_state == ST_SEAL;
  assign advance     = r_state == ST_ADVANCE;
  assign count_clear = advance && r_timer == TW'(ADV_CYCLES - 1);
  assign pallet_full = advance && w_timer_done && w_last_box;
  assign box_count   = r_box_count;
endmodule

// File: tb/tb_carton_packer_ctrl.sv
// tb_carton_packer_ctrl: cycle-position reference model plus directed literal checks and random stimulus.
module tb_carton_packer_ctrl;
  localparam int S = 4;
  localparam int A = 3;
  localparam int B = 10;
  logic       Ck = 0;
  logic       clear = 1;
  logic       run = 0;
  logic       dozen_done = 0;
  logic       feed_en, count_clear, seal, advance, pallet_full;
  logic [3:0] box_count;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic chk_en = 0;
  // Model: m_k is the position inside a box cycle (0 = not boxing), m_feed says whether feeding is wanted.
  int   m_k = 0;
  int   m_boxes = 0;
  logic m_feed = 0;
  logic m_prev = 1;
  logic m_rise;
  int   acc_seal, acc_cc, acc_pf;
  logic rd;

  carton_packer_ctrl #(.SEAL_CYCLES(S), .ADV_CYCLES(A), .BOXES_PER_PALLET(B)) dut (
    .Ck(Ck), .clear(clear), .run(run), .dozen_done(dozen_done),
    .feed_en(feed_en), .count_clear(count_clear), .seal(seal), .advance(advance),
    .box_count(box_count), .pallet_full(pallet_full)
  );

  always #5 Ck = ~Ck;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic hold(input int n, input logic c, input logic r, input logic d);
    for (int i = 0; i < n; i++) begin
      @(posedge Ck); #1;
      clear = c; run = r; dozen_done = d;
      @(negedge Ck);
      acc_seal += int'(seal);
      acc_cc   += int'(count_clear);
      acc_pf   += int'(pallet_full);
    end
  endtask

  always @(posedge Ck) begin
    if (clear) begin
      m_k = 0; m_boxes = 0; m_feed = 0; m_prev = 1;
    end else begin
      m_rise = dozen_done && !m_prev;
      if (m_k == 0) begin
        if (!m_feed) m_feed = run;
        else if (m_rise) m_k = 1;
        else if (!run) m_feed = 0;
      end else if (m_k < S + A) begin
        m_k++;
      end else begin
        m_k = 0;
        if (m_boxes == B - 1) begin
          m_boxes = 0; m_feed = 0;
        end else begin
          m_boxes++; m_feed = run;
        end
      end
      m_prev = dozen_done;
    end
  end

  always @(negedge Ck) begin
    if (chk_en) begin
      chk("feed_en", 32'(feed_en), 32'(m_k == 0 && m_feed));
      chk("seal", 32'(seal), 32'(m_k >= 1 && m_k <= S));
      chk("advance", 32'(advance), 32'(m_k > S && m_k <= S + A));
      chk("count_clear", 32'(count_clear), 32'(m_k == S + 1));
      chk("pallet_full", 32'(pallet_full), 32'(m_k == S + A && m_boxes == B - 1));
      chk("box_count", 32'(box_count), m_boxes);
    end
  end

  initial begin
    @(posedge Ck); #1;
    chk_en = 1;
    @(negedge Ck);
    chk("rst_feed", 32'(feed_en), 0);
    chk("rst_seal", 32'(seal), 0);
    chk("rst_adv", 32'(advance), 0);
    chk("rst_cc", 32'(count_clear), 0);
    chk("rst_pf", 32'(pallet_full), 0);
    chk("rst_box", 32'(box_count), 0);
    // First box: dozen edge in cycle 10.
    for (int c = 0; c <= 18; c++) begin
      hold(1, 0, 1, c == 10);
      if (c == 0) chk("r32_idle_feed", 32'(feed_en), 0);
      if (c == 1) chk("r32_fill_feed", 32'(feed_en), 1);
      if (c == 11 || c == 14) chk("r32_seal", 32'(seal), 1);
      if (c == 15) begin
        chk("r32_adv", 32'(advance), 1);
        chk("r32_cc", 32'(count_clear), 1);
        chk("r32_seal_off", 32'(seal), 0);
      end
      if (c == 16) chk("r32_cc_once", 32'(count_clear), 0);
      if (c == 17) chk("r32_adv_last", 32'(advance), 1);
      if (c == 18) begin
        chk("r32_box", 32'(box_count), 1);
        chk("r32_feed_back", 32'(feed_en), 1);
        chk("r32_adv_off", 32'(advance), 0);
      end
    end
    // Remaining nine boxes of the pallet.
    acc_pf = 0;
    for (int b = 0; b < 9; b++) begin
      hold(1, 0, 1, 1);
      hold(8, 0, 1, 0);
      if (b < 8) hold(1, 0, 1, 0);
    end
    chk("r33_pf_once", acc_pf, 1);
    chk("r33_box_wrap", 32'(box_count), 0);
    chk("r33_idle", 32'(feed_en), 0);
    hold(1, 0, 1, 0);
    chk("r33_refill", 32'(feed_en), 1);
    // Held level and toggles during SEAL each give one box only.
    acc_cc = 0;
    hold(20, 0, 1, 1);
    hold(5, 0, 1, 0);
    chk("r34_held_one_box", acc_cc, 1);
    acc_cc = 0;
    hold(1, 0, 1, 1);
    hold(1, 0, 1, 0);
    hold(1, 0, 1, 1);
    hold(1, 0, 1, 0);
    hold(1, 0, 1, 1);
    hold(1, 0, 1, 0);
    hold(10, 0, 1, 0);
    chk("r34_toggle_one_box", acc_cc, 1);
    // run dropped on the second SEAL cycle.
    hold(1, 0, 1, 1);
    hold(1, 0, 1, 0);
    hold(12, 0, 0, 0);
    chk("r35_box", 32'(box_count), 3);
    chk("r35_idle_feed", 32'(feed_en), 0);
    // clear on the second ADVANCE cycle.
    hold(1, 0, 1, 0);
    hold(1, 0, 1, 1);
    hold(5, 0, 1, 0);
    chk("r36_adv_before", 32'(advance), 1);
    hold(1, 1, 1, 0);
    hold(1, 0, 0, 0);
    chk("r36_adv", 32'(advance), 0);
    chk("r36_cc", 32'(count_clear), 0);
    chk("r36_seal", 32'(seal), 0);
    chk("r36_box", 32'(box_count), 0);
    // dozen_done already high through clear.
    acc_seal = 0;
    hold(2, 1, 0, 1);
    hold(10, 0, 1, 1);
    chk("r37_no_box", acc_seal, 0);
    hold(1, 0, 1, 0);
    hold(1, 0, 1, 1);
    hold(2, 0, 1, 0);
    chk("r37_box_after_rise", 32'(seal), 1);
    rd = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 6 == 0) rd = ~rd;
      hold(1, ($urandom % 300) == 0, ($urandom % 8) != 0, rd);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
